// File: rtl/fetch_unit.sv
// Instruction fetch sequencer between the program counter and the sync ROM.
// Emits 1-byte ALU instructions; resolves 2-byte JMP/JZ by reloading the PC.
module fetch_unit #(
   parameter int         ADDR_W = 12,
   parameter logic [3:0] JMP_OP = 4'hF,
   parameter logic [3:0] JZ_OP  = 4'hE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [ADDR_W-1:0] pc_value,
   output logic              pc_en,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_load_data,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   input  logic              zero_flag,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [3:0]        instr_opcode,
   output logic [3:0]        instr_operand,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              jump_taken
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CAPT,
      S_OUT,
      S_FETCH2,
      S_CAPT2,
      S_REDIR
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_instr_pc;
   logic [ADDR_W-1:0] r_target;
   logic [7:0]        r_byte;
   logic [3:0]        r_hi;
   logic              r_jz;
   logic              w_is_jmp;
   logic              w_is_jz;
   logic              w_take;

   assign w_is_jmp = (rom_data[7:4] == JMP_OP);
   assign w_is_jz  = (rom_data[7:4] == JZ_OP);
   assign w_take   = !r_jz || zero_flag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      pc_en       = 1'b0;
      pc_load     = 1'b0;
      jump_taken  = 1'b0;
      instr_valid = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (run) w_next = S_FETCH;
         end
         S_FETCH: begin
            pc_en = run;
            if (run) w_next = S_CAPT;
         end
         S_CAPT: begin
            if (w_is_jmp || w_is_jz) w_next = S_FETCH2;
            else                     w_next = S_OUT;
         end
         S_OUT: begin
            instr_valid = 1'b1;
            if (instr_ready) w_next = S_FETCH;
         end
         S_FETCH2: begin
            // second byte is fetched regardless of run
            pc_en  = 1'b1;
            w_next = S_CAPT2;
         end
         S_CAPT2: begin
            if (w_take) w_next = S_REDIR;
            else        w_next = S_FETCH;
         end
         S_REDIR: begin
            pc_load    = 1'b1;
            jump_taken = 1'b1;
            w_next     = S_FETCH;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_addr     <= '0;
         r_instr_pc <= '0;
         r_target   <= '0;
         r_byte     <= '0;
         r_hi       <= '0;
         r_jz       <= 1'b0;
      end else begin
         if (r_state == S_FETCH) begin
            r_addr <= pc_value;
         end
         if (r_state == S_CAPT) begin
            if (w_is_jmp || w_is_jz) begin
               r_hi <= rom_data[3:0];
               r_jz <= w_is_jz;
            end else begin
               r_byte     <= rom_data;
               r_instr_pc <= r_addr;
            end
         end
         // target only changes when a redirect will actually follow
         if (r_state == S_CAPT2 && w_take) begin
            r_target <= ADDR_W'({r_hi, rom_data});
         end
      end
   end

   assign rom_addr      = pc_value;
   assign pc_load_data  = r_target;
   assign instr_opcode  = r_byte[7:4];
   assign instr_operand = r_byte[3:0];
   assign instr_pc      = r_instr_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed cases plus random programs checked
// against an instruction-level model of the program.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic [11:0] pc_value;
   logic        pc_en;
   logic        pc_load;
   logic [11:0] pc_load_data;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic        zero_flag = 1'b0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [3:0]  instr_opcode;
   logic [3:0]  instr_operand;
   logic [11:0] instr_pc;
   logic        jump_taken;

   logic [7:0]  rom [0:4095];
   logic        preset_en = 1'b0;
   logic [11:0] preset_val = '0;
   int          n_chk = 0;
   int          n_pass = 0;
   logic [11:0] mpc;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .pc_value      (pc_value),
      .pc_en         (pc_en),
      .pc_load       (pc_load),
      .pc_load_data  (pc_load_data),
      .rom_addr      (rom_addr),
      .rom_data      (rom_data),
      .zero_flag     (zero_flag),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_opcode  (instr_opcode),
      .instr_operand (instr_operand),
      .instr_pc      (instr_pc),
      .jump_taken    (jump_taken)
   );

   // program counter and synchronous ROM models
   always @(posedge clk or posedge reset) begin
      if (reset)          pc_value <= '0;
      else if (preset_en) pc_value <= preset_val;
      else if (pc_load)   pc_value <= pc_load_data;
      else if (pc_en)     pc_value <= pc_value + 12'd1;
   end

   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic rom_clear();
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_event(input int max, output logic got_j,
                             output logic got_v, output int cyc);
      got_j = 1'b0;
      got_v = 1'b0;
      cyc = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         cyc++;
         if (jump_taken) begin
            got_j = 1'b1;
            return;
         end
         if (instr_valid) begin
            got_v = 1'b1;
            return;
         end
      end
   endtask

   // walk the program from mpc to the next visible step:
   // an emitted 1-byte instruction or a taken jump
   task automatic model_next(output logic is_jump, output logic [11:0] e_pc,
                             output logic [7:0] e_byte,
                             output logic [11:0] e_tgt);
      logic [7:0] b;
      logic [7:0] b2;
      is_jump = 1'b0;
      e_pc = '0;
      e_byte = '0;
      e_tgt = '0;
      for (int i = 0; i < 4096; i++) begin
         b = rom[mpc];
         if (b[7:4] == 4'hF || b[7:4] == 4'hE) begin
            b2 = rom[mpc + 12'd1];
            if (b[7:4] == 4'hF || zero_flag) begin
               is_jump = 1'b1;
               e_tgt = {b[3:0], b2};
               mpc = e_tgt;
               return;
            end
            mpc = mpc + 12'd2;
         end else begin
            e_pc = mpc;
            e_byte = b;
            mpc = mpc + 12'd1;
            return;
         end
      end
   endtask

   initial begin
      logic        gj, gv, isj;
      logic [11:0] epc, etgt;
      logic [7:0]  eb;
      int          cyc;
      bit          ev;

      // two sequential ALU instructions
      rom_clear();
      rom[0] = 8'h12;
      rom[1] = 8'h34;
      do_reset();
      check("rst_valid", instr_valid, 0);
      check("rst_pc_en", pc_en, 0);
      check("rst_load", pc_load, 0);
      check("rst_jump", jump_taken, 0);
      check("rst_ldata", pc_load_data, 0);
      check("rst_ipc", {instr_opcode, instr_operand, instr_pc}, 0);
      instr_ready = 1'b1;
      run = 1'b1;
      wait_event(10, gj, gv, cyc);
      check("t1_lat", cyc, 3);
      check("t1_i0", {instr_opcode, instr_operand, instr_pc}, 20'h12000);
      wait_event(10, gj, gv, cyc);
      check("t1_gap", cyc, 3);
      check("t1_i1", {instr_opcode, instr_operand, instr_pc}, 20'h34001);
      check("t1_pc", pc_value, 12'h002);

      // consumer back-pressure
      rom_clear();
      rom[0] = 8'h5A;
      do_reset();
      instr_ready = 1'b0;
      run = 1'b1;
      wait_event(10, gj, gv, cyc);
      check("t2_valid", gv, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t2_hold", {instr_valid, instr_opcode, instr_operand, instr_pc},
               {1'b1, 20'h5A000});
         check("t2_pc", pc_value, 12'h001);
      end
      instr_ready = 1'b1;
      @(negedge clk);
      check("t2_en1", {instr_valid, pc_en}, 2'b01);
      @(negedge clk);
      check("t2_en0", pc_en, 0);

      // unconditional jump
      rom_clear();
      rom[0] = 8'hF1;
      rom[1] = 8'h23;
      rom[12'h123] = 8'h77;
      do_reset();
      run = 1'b1;
      wait_event(12, gj, gv, cyc);
      check("t3_jump", gj, 1);
      check("t3_load", {pc_load, pc_en, pc_load_data}, {2'b10, 12'h123});
      wait_event(12, gj, gv, cyc);
      check("t3_next", {gv, instr_opcode, instr_operand, instr_pc},
            {1'b1, 20'h77123});

      // conditional jump, taken then not taken
      rom_clear();
      rom[0] = 8'hE4;
      rom[1] = 8'h56;
      rom[2] = 8'h21;
      rom[12'h456] = 8'h33;
      zero_flag = 1'b1;
      do_reset();
      run = 1'b1;
      wait_event(12, gj, gv, cyc);
      check("t4_jz1", {gj, pc_load, pc_load_data}, {2'b11, 12'h456});
      wait_event(12, gj, gv, cyc);
      check("t4_jz1n", {gv, instr_pc}, {1'b1, 12'h456});
      zero_flag = 1'b0;
      do_reset();
      run = 1'b1;
      wait_event(12, gj, gv, cyc);
      check("t4_jz0", {gj, gv, instr_opcode, instr_operand, instr_pc},
            {2'b01, 20'h21002});

      // jump straddling the top of memory
      rom_clear();
      rom[12'hFFF] = 8'hF0;
      rom[0] = 8'h10;
      do_reset();
      preset_val = 12'hFFF;
      preset_en = 1'b1;
      @(negedge clk);
      preset_en = 1'b0;
      check("t5_pre", pc_value, 12'hFFF);
      run = 1'b1;
      wait_event(12, gj, gv, cyc);
      check("t5_wrap", {gj, pc_load_data}, {1'b1, 12'h010});

      // reset in the middle of a jump
      rom_clear();
      rom[0] = 8'hF1;
      rom[1] = 8'h23;
      do_reset();
      run = 1'b1;
      gv = 1'b0;
      for (int i = 0; i < 10 && !gv; i++) begin
         @(negedge clk);
         if (pc_en && pc_value == 12'h001) gv = 1'b1;
      end
      check("t6_f2", gv, 1);
      reset = 1'b1;
      #1;
      check("t6_out", {pc_en, pc_load, instr_valid, jump_taken, pc_load_data,
                      instr_pc}, 0);
      run = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      gj = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         gj = gj | pc_load;
      end
      check("t6_noload", gj, 0);
      run = 1'b1;
      @(negedge clk);
      check("t6_restart", {pc_en, pc_value, rom_addr}, {1'b1, 24'h000000});

      // random programs against the instruction-level model
      for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
      zero_flag = 1'($urandom);
      do_reset();
      mpc = '0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge clk);
         run = ($urandom_range(0, 9) < 8);
         instr_ready = ($urandom_range(0, 9) < 7);
         ev = 0;
         if (pc_en && pc_load) check("excl", 1, 0);
         if (jump_taken) begin
            model_next(isj, epc, eb, etgt);
            check("r_jump", {isj, pc_load, pc_load_data}, {2'b11, etgt});
            ev = 1;
         end else if (instr_valid && instr_ready) begin
            model_next(isj, epc, eb, etgt);
            check("r_instr", {isj, instr_opcode, instr_operand, instr_pc},
                  {1'b0, eb, epc});
            ev = 1;
         end
         if (ev) zero_flag = 1'($urandom);
      end
      check("r_events", (n_chk > 200), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
